// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared constants, state encoding and status decode for lock_sequencer
// Contents:
//   state_t       3-bit state encoding: IDLE=0 ENTRY=1 CHECK=2 OPEN=3 PROG=4 LOCKOUT=5
//   status_t      registered status flags driven onto the status outputs
//   LOCK_*        default parameter values, including the reset code
//   *_width()     width helpers derived from CODE_LEN / MAX_FAIL / LOCKOUT_CYCLES
package lock_pkg;

    localparam int LOCK_CODE_LEN       = 4;
    localparam int LOCK_DIGIT_W        = 4;
    localparam int LOCK_MAX_FAIL       = 3;
    localparam int LOCK_LOCKOUT_CYCLES = 50000000;
    // Digit 0 lives in the most significant nibble.
    localparam logic [LOCK_CODE_LEN*LOCK_DIGIT_W-1:0] LOCK_DEFAULT_CODE = 16'h9130;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_PROG    = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    typedef struct packed {
        logic unlocked;
        logic locked_out;
        logic prog_mode;
        logic armed;
    } status_t;

    function automatic int idx_width(input int code_len);
        return (code_len > 1) ? $clog2(code_len) : 1;
    endfunction

    function automatic int fail_width(input int max_fail);
        return $clog2(max_fail + 1);
    endfunction

    function automatic int timer_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    function automatic status_t status_of(input state_t s);
        status_t st;
        st            = '0;
        st.unlocked   = (s == S_OPEN) || (s == S_PROG);
        st.locked_out = (s == S_LOCKOUT);
        st.prog_mode  = (s == S_PROG);
        st.armed      = (s == S_ENTRY);
        return st;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// rtl/lock_sequencer_if.sv - switch/button inputs and status outputs of lock_sequencer
// Signals:
//   SW, KEY_ENTER, KEY_PROG          board inputs (raw, asynchronous buttons)
//   unlocked, locked_out, prog_mode  status flags
//   armed, digit_idx, fail_cnt       entry progress and failure count
//   state_o                          state encoding for LED debug
// Modports: master drives the board inputs, slave is the sequencer.
interface lock_sequencer_if #(
    parameter int CODE_LEN = 4,
    parameter int DIGIT_W  = 4,
    parameter int MAX_FAIL = 3
);
    import lock_pkg::*;

    localparam int IDX_W  = idx_width(CODE_LEN);
    localparam int FAIL_W = fail_width(MAX_FAIL);

    logic [DIGIT_W-1:0] SW;
    logic               KEY_ENTER;
    logic               KEY_PROG;
    logic               unlocked;
    logic               locked_out;
    logic               prog_mode;
    logic               armed;
    logic [IDX_W-1:0]   digit_idx;
    logic [FAIL_W-1:0]  fail_cnt;
    logic [2:0]         state_o;

    modport master (
        output SW, KEY_ENTER, KEY_PROG,
        input  unlocked, locked_out, prog_mode, armed, digit_idx, fail_cnt, state_o
    );

    modport slave (
        input  SW, KEY_ENTER, KEY_PROG,
        output unlocked, locked_out, prog_mode, armed, digit_idx, fail_cnt, state_o
    );

endinterface

// File: rtl/key_sync_edge.sv
// rtl/key_sync_edge.sv - 2-FF synchronizer and rising-edge detector for a raw push button
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   key_raw  in   raw active-high button, asynchronous to clk
//   strobe   out  one-cycle pulse, high 3 clocks after the raw rising edge
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic strobe
);
    // sync[1:0] is the synchronizer; sync[2] is the previous synchronized
    // level for edge detection. The strobe is registered so a press lands
    // exactly three clocks after the raw edge and a held key pulses once.
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            strobe <= 1'b0;
        end else begin
            sync   <= {sync[1:0], key_raw};
            strobe <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/lock_sequencer.sv
// rtl/lock_sequencer.sv - code-entry sequencer for the switch combination lock
// Ports:
//   CLOCK_50  in  system clock, 50 MHz
//   RESET_N   in  asynchronous active-low reset
//   bus       slave modport of lock_sequencer_if (SW, KEY_ENTER, KEY_PROG in;
//             unlocked, locked_out, prog_mode, armed, digit_idx, fail_cnt, state_o out)
// The code is entered as a leading 0 (arm) followed by CODE_LEN digits, each
// latched from SW on an enter press. MAX_FAIL consecutive failures lock the
// sequencer out for LOCKOUT_CYCLES cycles. While open, the code can be
// reprogrammed through a shadow register that only commits on the last digit.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int                             CODE_LEN       = LOCK_CODE_LEN,
    parameter int                             DIGIT_W        = LOCK_DIGIT_W,
    parameter int                             MAX_FAIL       = LOCK_MAX_FAIL,
    parameter int                             LOCKOUT_CYCLES = LOCK_LOCKOUT_CYCLES,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = LOCK_DEFAULT_CODE
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    lock_sequencer_if.slave  bus
);

    localparam int IDX_W   = idx_width(CODE_LEN);
    localparam int FAIL_W  = fail_width(MAX_FAIL);
    localparam int TIMER_W = timer_width(LOCKOUT_CYCLES);
    localparam int CODE_W  = CODE_LEN * DIGIT_W;

    logic enter_stb;
    logic prog_stb;

    key_sync_edge u_enter_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .key_raw (bus.KEY_ENTER),
        .strobe  (enter_stb)
    );

    key_sync_edge u_prog_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .key_raw (bus.KEY_PROG),
        .strobe  (prog_stb)
    );

    state_t              state;
    status_t             status;
    logic [CODE_W-1:0]   code;
    logic [DIGIT_W-1:0]  shadow [CODE_LEN];
    logic [IDX_W-1:0]    digit_idx;
    logic [FAIL_W-1:0]   fail_cnt;
    logic                mismatch;
    logic [TIMER_W-1:0]  timer;

    logic [DIGIT_W-1:0]  cur_digit;
    logic [CODE_W-1:0]   shadow_commit;
    logic [FAIL_W-1:0]   fail_inc;
    logic                sw_zero;
    logic                last_digit;

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_digit = code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
            end
        end
    end

    // Commit only happens on the last digit, so its value comes straight
    // from SW rather than from the shadow slot being written this cycle.
    always_comb begin
        shadow_commit = '0;
        for (int i = 0; i < CODE_LEN - 1; i++) begin
            shadow_commit[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = shadow[i];
        end
        shadow_commit[DIGIT_W-1:0] = bus.SW;
    end

    assign fail_inc   = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_W'(1);
    assign sw_zero    = (bus.SW == '0);
    assign last_digit = (digit_idx == IDX_W'(CODE_LEN - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            status    <= '0;
            code      <= DEFAULT_CODE;
            digit_idx <= '0;
            fail_cnt  <= '0;
            mismatch  <= 1'b0;
            timer     <= '0;
            for (int i = 0; i < CODE_LEN; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (enter_stb && sw_zero) begin
                        state     <= S_ENTRY;
                        status    <= status_of(S_ENTRY);
                        digit_idx <= '0;
                        mismatch  <= 1'b0;
                    end
                end

                // Every digit is collected before judging, so the time to
                // reject does not reveal which digit was wrong.
                S_ENTRY: begin
                    if (enter_stb) begin
                        if (bus.SW != cur_digit) begin
                            mismatch <= 1'b1;
                        end
                        if (last_digit) begin
                            state  <= S_CHECK;
                            status <= status_of(S_CHECK);
                        end else begin
                            digit_idx <= digit_idx + IDX_W'(1);
                        end
                    end
                end

                S_CHECK: begin
                    if (!mismatch) begin
                        state    <= S_OPEN;
                        status   <= status_of(S_OPEN);
                        fail_cnt <= '0;
                    end else begin
                        fail_cnt <= fail_inc;
                        if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                            state  <= S_LOCKOUT;
                            status <= status_of(S_LOCKOUT);
                            timer  <= TIMER_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            state  <= S_IDLE;
                            status <= status_of(S_IDLE);
                        end
                    end
                end

                // Program has priority so a simultaneous press never relocks.
                S_OPEN: begin
                    if (prog_stb) begin
                        state     <= S_PROG;
                        status    <= status_of(S_PROG);
                        digit_idx <= '0;
                    end else if (enter_stb && sw_zero) begin
                        state  <= S_IDLE;
                        status <= status_of(S_IDLE);
                    end
                end

                // A prog press aborts; the shadow is simply left unused.
                S_PROG: begin
                    if (prog_stb) begin
                        state  <= S_OPEN;
                        status <= status_of(S_OPEN);
                    end else if (enter_stb) begin
                        shadow[digit_idx] <= bus.SW;
                        if (last_digit) begin
                            code   <= shadow_commit;
                            state  <= S_OPEN;
                            status <= status_of(S_OPEN);
                        end else begin
                            digit_idx <= digit_idx + IDX_W'(1);
                        end
                    end
                end

                // Timer is loaded with LOCKOUT_CYCLES-1 and the exit happens
                // on the cycle it reads 0, giving exactly LOCKOUT_CYCLES here.
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state    <= S_IDLE;
                        status   <= status_of(S_IDLE);
                        fail_cnt <= '0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    status <= '0;
                end
            endcase
        end
    end

    assign bus.unlocked   = status.unlocked;
    assign bus.locked_out = status.locked_out;
    assign bus.prog_mode  = status.prog_mode;
    assign bus.armed      = status.armed;
    assign bus.digit_idx  = digit_idx;
    assign bus.fail_cnt   = fail_cnt;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb/tb_lock_sequencer.sv - self-checking bench for lock_sequencer against a reference model
module tb_lock_sequencer;

    localparam int CL = 4;
    localparam int MF = 3;
    localparam int L  = 20;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lock_sequencer_if #(.CODE_LEN(CL), .DIGIT_W(4), .MAX_FAIL(MF)) bus_if ();

    lock_sequencer #(.LOCKOUT_CYCLES(L)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .bus      (bus_if)
    );

    // Reference model: lock states as plain integers (0 idle, 1 entry,
    // 2 check, 3 open, 4 prog, 5 lockout); codes as digit arrays; the
    // CHECK and LOCKOUT exits are timestamped events on clock edge numbers.
    int m_state, m_idx, m_fail, m_mis, m_ce, m_le;
    int m_code [CL];
    int m_shadow [CL];

    task automatic m_reset();
        m_state  = 0;
        m_idx    = 0;
        m_fail   = 0;
        m_mis    = 0;
        m_code   = '{9, 1, 3, 0};
        m_shadow = '{0, 0, 0, 0};
    endtask

    task automatic settle(input int upto);
        if (m_state == 2 && m_ce + 1 <= upto) begin
            if (m_mis == 0) begin
                m_state = 3;
                m_fail  = 0;
            end else begin
                m_fail = (m_fail < MF) ? m_fail + 1 : MF;
                if (m_fail == MF) begin
                    m_state = 5;
                    m_le    = m_ce + 1;
                end else begin
                    m_state = 0;
                end
            end
        end
        if (m_state == 5 && m_le + L <= upto) begin
            m_state = 0;
            m_fail  = 0;
        end
    endtask

    task automatic step(input int n, input bit e, input bit p, input int sw);
        settle(n - 1);
        if (m_state == 2 || m_state == 5) begin
            settle(n);
            return;
        end
        case (m_state)
            0: if (e && sw == 0) begin m_state = 1; m_idx = 0; m_mis = 0; end
            1: if (e) begin
                   if (sw != m_code[m_idx]) m_mis = 1;
                   if (m_idx == CL - 1) begin m_state = 2; m_ce = n; end
                   else m_idx++;
               end
            3: if (p) begin m_state = 4; m_idx = 0; end
               else if (e && sw == 0) m_state = 0;
            4: if (p) m_state = 3;
               else if (e) begin
                   m_shadow[m_idx] = sw;
                   if (m_idx == CL - 1) begin m_code = m_shadow; m_state = 3; end
                   else m_idx++;
               end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":state_o"},    32'(bus_if.state_o),    32'(m_state));
        chk({tag, ":unlocked"},   32'(bus_if.unlocked),   32'(m_state == 3 || m_state == 4));
        chk({tag, ":locked_out"}, 32'(bus_if.locked_out), 32'(m_state == 5));
        chk({tag, ":prog_mode"},  32'(bus_if.prog_mode),  32'(m_state == 4));
        chk({tag, ":armed"},      32'(bus_if.armed),      32'(m_state == 1));
        chk({tag, ":digit_idx"},  32'(bus_if.digit_idx),  32'(m_idx));
        chk({tag, ":fail_cnt"},   32'(bus_if.fail_cnt),   32'(m_fail));
    endtask

    // One button press: outputs must be unchanged after 3 edges and show
    // the effect after the 4th; then the key is released for 3 edges.
    task automatic press(input string tag, input bit e, input bit p, input int sw);
        @(negedge clk);
        bus_if.SW        = 4'(sw);
        bus_if.KEY_ENTER = e;
        bus_if.KEY_PROG  = p;
        repeat (3) @(posedge clk);
        #1;
        settle(cyc);
        check_all({tag, ":pre"});
        @(posedge clk);
        #1;
        step(cyc, e, p, sw);
        check_all(tag);
        @(negedge clk);
        bus_if.KEY_ENTER = 1'b0;
        bus_if.KEY_PROG  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            settle(cyc);
            check_all({tag, ":gap"});
        end
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            settle(cyc);
            check_all(tag);
        end
    endtask

    task automatic enter_code(input string tag, input int d0, input int d1, input int d2, input int d3);
        press({tag, ":arm"}, 1, 0, 0);
        press({tag, ":d0"}, 1, 0, d0);
        press({tag, ":d1"}, 1, 0, d1);
        press({tag, ":d2"}, 1, 0, d2);
        press({tag, ":d3"}, 1, 0, d3);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        idle({tag, ":post"}, 2);
    endtask

    initial begin
        int r, sw;
        bit e, p;
        rst_n            = 1'b0;
        bus_if.SW        = '0;
        bus_if.KEY_ENTER = 1'b0;
        bus_if.KEY_PROG  = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("after_reset", 2);

        press("idle_sw6", 1, 0, 6);
        chk("idle_sw6_state", 32'(bus_if.state_o), 32'd0);
        press("idle_prog", 0, 1, 0);
        press("arm", 1, 0, 0);
        chk("arm_armed", 32'(bus_if.armed), 32'd1);

        press("ok:d0", 1, 0, 9);
        press("ok:d1", 1, 0, 1);
        press("ok:d2", 1, 0, 3);
        @(negedge clk);
        bus_if.SW = 4'd0;
        bus_if.KEY_ENTER = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        step(cyc, 1, 0, 0);
        check_all("ok:d3");
        chk("ok_check_state", 32'(bus_if.state_o), 32'd2);
        @(posedge clk);
        #1;
        settle(cyc);
        check_all("ok:open");
        chk("ok_unlocked", 32'(bus_if.unlocked), 32'd1);
        @(negedge clk);
        bus_if.KEY_ENTER = 1'b0;
        idle("ok:rel", 3);

        press("relock", 1, 0, 0);

        enter_code("bad1", 9, 1, 3, 1);
        chk("bad1_fail", 32'(bus_if.fail_cnt), 32'd1);
        enter_code("bad2", 9, 1, 3, 1);
        enter_code("bad3", 9, 1, 3, 1);
        chk("bad3_locked", 32'(bus_if.locked_out), 32'd1);
        press("lock_ignore", 1, 0, 0);
        chk("lock_ignore_state", 32'(bus_if.state_o), 32'd5);
        idle("lockout", 14);
        chk("lock_exit_state", 32'(bus_if.state_o), 32'd0);
        chk("lock_exit_fail", 32'(bus_if.fail_cnt), 32'd0);

        enter_code("open", 9, 1, 3, 0);
        press("prog", 0, 1, 0);
        press("prog:d0", 1, 0, 2);
        press("prog:d1", 1, 0, 2);
        press("prog:d2", 1, 0, 5);
        press("prog:d3", 1, 0, 7);
        press("relock2", 1, 0, 0);
        enter_code("old_code", 9, 1, 3, 0);
        chk("old_code_fail", 32'(bus_if.fail_cnt), 32'd1);
        enter_code("new_code", 2, 2, 5, 7);
        chk("new_code_open", 32'(bus_if.unlocked), 32'd1);

        press("both", 1, 1, 0);
        chk("both_prog", 32'(bus_if.prog_mode), 32'd1);
        press("abort:d0", 1, 0, 4);
        press("abort", 0, 1, 0);
        press("relock3", 1, 0, 0);
        enter_code("unchanged", 2, 2, 5, 7);
        chk("unchanged_open", 32'(bus_if.state_o), 32'd3);

        press("relock4", 1, 0, 0);
        press("mid_entry:arm", 1, 0, 0);
        press("mid_entry:d0", 1, 0, 2);
        press("mid_entry:d1", 1, 0, 2);
        async_reset("rst_entry");
        enter_code("after_rst1", 9, 1, 3, 0);

        press("mid_prog", 0, 1, 0);
        press("mid_prog:d0", 1, 0, 1);
        press("mid_prog:d1", 1, 0, 1);
        async_reset("rst_prog");
        enter_code("after_rst2", 9, 1, 3, 0);
        chk("after_rst2_open", 32'(bus_if.unlocked), 32'd1);

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            e = 1'b0;
            p = 1'b0;
            if (m_state == 1 && $urandom_range(0, 3) != 0) sw = m_code[m_idx];
            else if ($urandom_range(0, 2) == 0) sw = 0;
            else sw = $urandom_range(0, 15);
            if (r <= 5) e = 1'b1;
            else if (r <= 7) p = 1'b1;
            else if (r == 8) begin e = 1'b1; p = 1'b1; end
            if (r == 9) idle("rnd_idle", $urandom_range(1, 8));
            else press("rnd", e, p, sw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
